// File: rtl/residual_stream_out.sv
// residual_stream_out: captures one flat SEQ_LEN x EMB_DIM tensor in a single
// handshake and replays it as a row-major element stream tagged with its
// row/column position. Elements pass through bit-exact.
module residual_stream_out #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 8,
  parameter int EMB_DIM    = 8,
  localparam int RW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int CW = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] in_data,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [RW-1:0]                         out_row,
  output logic [CW-1:0]                         out_col,
  output logic                                  out_last_col,
  output logic                                  out_last,
  output logic                                  done
);

  localparam int unsigned N  = SEQ_LEN * EMB_DIM;
  localparam int          KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] buffer [N];
  logic [RW-1:0]         r;
  logic [CW-1:0]         c;
  // Flat element index kept alongside r/c so the buffer read is a plain
  // array lookup instead of an r*EMB_DIM+c multiply.
  logic [KW-1:0]         k;

  logic is_last_col, is_last_row, load, xfer;

  assign is_last_col = (c == CW'(EMB_DIM - 1));
  assign is_last_row = (r == RW'(SEQ_LEN - 1));
  assign load        = in_valid && in_ready;
  assign xfer        = out_valid && out_ready;

  // State register; reset is synchronous and active-high despite the port name.
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and state-decoded handshake/status outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_STREAM;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        if (out_ready && is_last_col && is_last_row) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Tensor capture and row-major position counters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < N; i++) buffer[i] <= '0;
      r <= '0;
      c <= '0;
      k <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < N; i++) buffer[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      r <= '0;
      c <= '0;
      k <= '0;
    end else if (xfer) begin
      if (is_last_col) begin
        c <= '0;
        r <= is_last_row ? '0 : r + RW'(1);
      end else begin
        c <= c + CW'(1);
      end
      k <= (is_last_col && is_last_row) ? '0 : k + KW'(1);
    end
  end

  // Outputs come from registered state only; element and tags read zero outside the stream.
  always_comb begin
    out_data     = out_valid ? buffer[k] : '0;
    out_row      = r;
    out_col      = c;
    out_last_col = out_valid && is_last_col;
    out_last     = out_valid && is_last_col && is_last_row;
  end

endmodule

// File: tb/tb_residual_stream_out.sv
// Bench for residual_stream_out: a default 8x8 instance and a 3x5 instance,
// driven by directed steps with a scoreboard queue of expected elements.
module tb_residual_stream_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [16*64-1:0] in_data_a = '0;
  logic [16*15-1:0] in_data_b = '0;

  logic a_in_ready, a_valid, a_lc, a_last, a_done;
  logic [15:0] a_data;
  logic [2:0]  a_row, a_col;
  logic b_in_ready, b_valid, b_lc, b_last, b_done;
  logic [15:0] b_data;
  logic [1:0]  b_row;
  logic [2:0]  b_col;

  logic iv_a, iv_b;
  assign iv_a = in_valid && !sel;
  assign iv_b = in_valid && sel;

  always #5 clk = ~clk;

  residual_stream_out #(.DATA_WIDTH(16), .SEQ_LEN(8), .EMB_DIM(8)) dut_a (
    .clk(clk), .rst_n(rst), .in_valid(iv_a), .in_ready(a_in_ready), .in_data(in_data_a),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready), .out_row(a_row),
    .out_col(a_col), .out_last_col(a_lc), .out_last(a_last), .done(a_done)
  );

  residual_stream_out #(.DATA_WIDTH(16), .SEQ_LEN(3), .EMB_DIM(5)) dut_b (
    .clk(clk), .rst_n(rst), .in_valid(iv_b), .in_ready(b_in_ready), .in_data(in_data_b),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready), .out_row(b_row),
    .out_col(b_col), .out_last_col(b_lc), .out_last(b_last), .done(b_done)
  );

  logic [31:0] obs_data, obs_row, obs_col;
  logic obs_valid, obs_lc, obs_last, obs_done, obs_inready;
  assign obs_data    = sel ? 32'(b_data) : 32'(a_data);
  assign obs_row     = sel ? 32'(b_row) : 32'(a_row);
  assign obs_col     = sel ? 32'(b_col) : 32'(a_col);
  assign obs_valid   = sel ? b_valid : a_valid;
  assign obs_lc      = sel ? b_lc : a_lc;
  assign obs_last    = sel ? b_last : a_last;
  assign obs_done    = sel ? b_done : a_done;
  assign obs_inready = sel ? b_in_ready : a_in_ready;

  typedef struct {
    logic [15:0] data;
    int          row;
    int          col;
    bit          lc;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive a tensor on the selected instance's in_data and queue its elements.
  // mode 0: 16'h0100+k, mode 1: all 16'h7FFF, mode 2: alternating 16'h8000/16'h7FFF.
  task automatic load_tensor(input int mode);
    int n, e;
    logic [15:0] v;
    exp_t x;
    n = sel ? 15 : 64;
    e = sel ? 5 : 8;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       v = 16'h0100 + 16'(k);
        1:       v = 16'h7FFF;
        default: v = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
      endcase
      if (sel) in_data_b[k*16 +: 16] = v;
      else     in_data_a[k*16 +: 16] = v;
      x.data = v;
      x.row  = k / e;
      x.col  = k % e;
      x.lc   = (k % e) == e - 1;
      x.last = (k == n - 1);
      sb.push_back(x);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the capture edge.
  task automatic capture();
    check("in_ready_before_capture", 32'(obs_inready), 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("valid_after_capture", 32'(obs_valid), 32'd1);
  endtask

  // Consume ntx elements with out_ready low for roughly bp percent of cycles.
  task automatic run_stream(input int ntx, input int bp, input bit finish);
    int n = 0;
    int budget = 0;
    bit held = 1'b0;
    logic [31:0] sd, sr, scol;
    exp_t e;
    while (n < ntx && budget < 4000) begin
      if (held) begin
        check("hold_data", obs_data, sd);
        check("hold_row", obs_row, sr);
        check("hold_col", obs_col, scol);
      end
      check("stream_valid", 32'(obs_valid), 32'd1);
      check("busy_in_ready", 32'(obs_inready), 32'd0);
      check("no_early_done", 32'(obs_done), 32'd0);
      out_ready = ($urandom_range(0, 99) >= 32'(bp));
      if (out_ready) begin
        e = sb.pop_front();
        check("data", obs_data, 32'(e.data));
        check("row", obs_row, 32'(e.row));
        check("col", obs_col, 32'(e.col));
        check("last_col", 32'(obs_lc), 32'(e.lc));
        check("last", 32'(obs_last), 32'(e.last));
        n++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        sd   = obs_data;
        sr   = obs_row;
        scol = obs_col;
      end
      @(negedge clk);
      budget++;
    end
    if (budget >= 4000) check("stream_timeout", 32'(n), 32'(ntx));
    if (finish) begin
      check("done_pulse", 32'(obs_done), 32'd1);
      check("done_valid", 32'(obs_valid), 32'd0);
      check("done_in_ready", 32'(obs_inready), 32'd0);
      @(negedge clk);
      check("done_cleared", 32'(obs_done), 32'd0);
      check("idle_in_ready", 32'(obs_inready), 32'd1);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(obs_inready), 32'd1);
    check({tag, "_valid"}, 32'(obs_valid), 32'd0);
    check({tag, "_done"}, 32'(obs_done), 32'd0);
    check({tag, "_data"}, obs_data, 32'd0);
    check({tag, "_row"}, obs_row, 32'd0);
    check({tag, "_col"}, obs_col, 32'd0);
    check({tag, "_last_col"}, 32'(obs_lc), 32'd0);
    check({tag, "_last"}, 32'(obs_last), 32'd0);
  endtask

  initial begin
    // Reset for two edges, then both instances idle with zeroed outputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset_a");
    sel = 1'b1;
    check_idle("reset_b");
    sel = 1'b0;
    @(negedge clk);
    check_idle("idle_a");

    // Full-rate stream.
    load_tensor(0);
    capture();
    run_stream(64, 0, 1);

    // Random backpressure.
    load_tensor(0);
    capture();
    run_stream(64, 50, 1);

    // Second tensor offered during stream and done; accepted once idle.
    load_tensor(0);
    capture();
    load_tensor(1);
    in_valid = 1'b1;
    run_stream(64, 20, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("second_capture_valid", 32'(obs_valid), 32'd1);
    run_stream(64, 0, 1);

    // Reset after the 20th transfer aborts the stream without done.
    load_tensor(0);
    capture();
    run_stream(20, 0, 0);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(obs_valid), 32'd0);
    check("midrst_done", 32'(obs_done), 32'd0);
    check("midrst_in_ready", 32'(obs_inready), 32'd1);
    check("midrst_data", obs_data, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_done", 32'(obs_done), 32'd0);
      check("postrst_in_ready", 32'(obs_inready), 32'd1);
    end
    load_tensor(0);
    capture();
    run_stream(64, 0, 1);

    // Non-square 3x5 instance with boundary values.
    sel = 1'b1;
    @(negedge clk);
    load_tensor(2);
    capture();
    run_stream(15, 0, 1);
    load_tensor(2);
    capture();
    run_stream(15, 40, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
